// File: rtl/sdram_init_gen.sv
// SDRAM power-up initialisation sequencer: wait, PRECHARGE ALL, N x AUTO REFRESH,
// MODE REGISTER SET, then signal completion. Supports re-init without the power-up wait.
module sdram_init_gen #(
    parameter int         CLK_FREQ_MHZ = 100,
    parameter int         POWERUP_US   = 200,
    parameter int         T_RP         = 2,
    parameter int         T_RFC        = 7,
    parameter int         T_MRD        = 2,
    parameter int         REF_NUM      = 2,
    parameter logic [2:0] CAS_LAT      = 3'd3,
    parameter logic [2:0] BURST_LEN    = 3'b010,
    parameter logic       BURST_TYPE   = 1'b0,
    parameter int         ADDR_W       = 13
) (
    input  logic              sysclk,
    input  logic              rst,
    input  logic              reinit_req,
    output logic [3:0]        cmd_reg,
    output logic [1:0]        sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic              init_end_flag,
    output logic              busy
);

    localparam int POWERUP_CYC = CLK_FREQ_MHZ * POWERUP_US;
    localparam int PW          = $clog2(POWERUP_CYC + 1);

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_MRS = 4'b0000;

    localparam logic [PW-1:0]     PWR_LAST = PW'(POWERUP_CYC);
    // Wait states last (tXX - 1) cycles, so their counters stop at tXX - 2.
    localparam logic [7:0]        TRP_LAST = 8'(T_RP - 2);
    localparam logic [7:0]        TRFC_LAST = 8'(T_RFC - 2);
    localparam logic [7:0]        TMRD_LAST = 8'(T_MRD - 2);
    localparam logic [3:0]        REF_LAST = 4'(REF_NUM);
    localparam logic [ADDR_W-1:0] ADDR_A10 = ADDR_W'(11'h400);
    localparam logic [ADDR_W-1:0] ADDR_MODE = ADDR_W'({3'b000, CAS_LAT, BURST_TYPE, BURST_LEN});

    typedef enum logic [2:0] {
        S_PWRUP = 3'd0,
        S_PRE   = 3'd1,
        S_TRP   = 3'd2,
        S_REF   = 3'd3,
        S_TRFC  = 3'd4,
        S_MRS   = 3'd5,
        S_TMRD  = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    state_t            state_r, state_s;
    logic [PW-1:0]     pwr_cnt_r, pwr_cnt_s;
    logic [7:0]        dly_cnt_r, dly_cnt_s;
    logic [3:0]        ref_cnt_r, ref_cnt_s;
    logic [3:0]        cmd_s;
    logic [ADDR_W-1:0] addr_s;

    // Next-state, counter and next-output decode; outputs are registered from the next state.
    always_comb begin
        state_s   = state_r;
        pwr_cnt_s = pwr_cnt_r;
        dly_cnt_s = dly_cnt_r;
        ref_cnt_s = ref_cnt_r;
        case (state_r)
            S_PWRUP: begin
                if (pwr_cnt_r == PWR_LAST) begin
                    state_s = S_PRE;
                end else begin
                    pwr_cnt_s = pwr_cnt_r + PW'(1);
                end
            end
            S_PRE: begin
                dly_cnt_s = 8'd0;
                ref_cnt_s = 4'd0;
                state_s   = (T_RP == 1) ? S_REF : S_TRP;
            end
            S_TRP: begin
                if (dly_cnt_r == TRP_LAST) begin
                    dly_cnt_s = 8'd0;
                    state_s   = S_REF;
                end else begin
                    dly_cnt_s = dly_cnt_r + 8'd1;
                end
            end
            S_REF: begin
                dly_cnt_s = 8'd0;
                ref_cnt_s = ref_cnt_r + 4'd1;
                if (T_RFC != 1) begin
                    state_s = S_TRFC;
                end else if (ref_cnt_s == REF_LAST) begin
                    state_s = S_MRS;
                end else begin
                    state_s = S_REF;
                end
            end
            S_TRFC: begin
                if (dly_cnt_r == TRFC_LAST) begin
                    dly_cnt_s = 8'd0;
                    state_s   = (ref_cnt_r == REF_LAST) ? S_MRS : S_REF;
                end else begin
                    dly_cnt_s = dly_cnt_r + 8'd1;
                end
            end
            S_MRS: begin
                dly_cnt_s = 8'd0;
                state_s   = (T_MRD == 1) ? S_DONE : S_TMRD;
            end
            S_TMRD: begin
                if (dly_cnt_r == TMRD_LAST) begin
                    dly_cnt_s = 8'd0;
                    state_s   = S_DONE;
                end else begin
                    dly_cnt_s = dly_cnt_r + 8'd1;
                end
            end
            S_DONE: begin
                if (reinit_req) begin
                    state_s = S_PRE;
                end else begin
                    state_s = S_DONE;
                end
            end
            default: begin
                state_s   = S_PWRUP;
                pwr_cnt_s = '0;
                dly_cnt_s = 8'd0;
                ref_cnt_s = 4'd0;
            end
        endcase

        case (state_s)
            S_PRE:   cmd_s = CMD_PRE;
            S_REF:   cmd_s = CMD_REF;
            S_MRS:   cmd_s = CMD_MRS;
            default: cmd_s = CMD_NOP;
        endcase
        if (state_s == S_MRS) begin
            addr_s = ADDR_MODE;
        end else begin
            addr_s = ADDR_A10;
        end
    end

    // State, counters and registered outputs; rst overrides any reinit request.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_r       <= S_PWRUP;
            pwr_cnt_r     <= '0;
            dly_cnt_r     <= 8'd0;
            ref_cnt_r     <= 4'd0;
            cmd_reg       <= CMD_NOP;
            sdram_addr    <= ADDR_A10;
            sdram_ba      <= 2'b00;
            init_end_flag <= 1'b0;
            busy          <= 1'b1;
        end else begin
            state_r       <= state_s;
            pwr_cnt_r     <= pwr_cnt_s;
            dly_cnt_r     <= dly_cnt_s;
            ref_cnt_r     <= ref_cnt_s;
            cmd_reg       <= cmd_s;
            sdram_addr    <= addr_s;
            sdram_ba      <= 2'b00;
            init_end_flag <= (state_s == S_DONE);
            busy          <= (state_s != S_DONE);
        end
    end

endmodule

// File: tb/tb_sdram_init_gen.sv
// Scoreboard bench for sdram_init_gen: expected commands and flag changes are queued per
// scenario and matched against what the selected instance emits, cycle by cycle.
module tb_sdram_init_gen;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] REF = 4'b0001;
    localparam logic [3:0] MRS = 4'b0000;

    logic             clk = 1'b0;
    logic [3:0]       rst_w = 4'hF;
    logic [3:0]       reinit_w = 4'h0;
    logic [3:0][3:0]  cmd_w;
    logic [3:0][1:0]  ba_w;
    logic [3:0][12:0] addr_w;
    logic [3:0]       flag_w;
    logic [3:0]       busy_w;

    typedef struct {
        int cyc;
        int kind;
        int val;
    } ev_t;

    ev_t sb[$];
    int  total = 0;
    int  bad = 0;

    always #5 clk = ~clk;

    // 0: defaults; 1: REF_NUM=4,T_RFC=3; 2: alternate mode word; 3: T_RP=1,T_MRD=1
    sdram_init_gen #(.CLK_FREQ_MHZ(10), .POWERUP_US(1)) u_nom (
        .sysclk(clk), .rst(rst_w[0]), .reinit_req(reinit_w[0]), .cmd_reg(cmd_w[0]),
        .sdram_ba(ba_w[0]), .sdram_addr(addr_w[0]), .init_end_flag(flag_w[0]), .busy(busy_w[0]));
    sdram_init_gen #(.CLK_FREQ_MHZ(10), .POWERUP_US(1), .REF_NUM(4), .T_RFC(3)) u_ref4 (
        .sysclk(clk), .rst(rst_w[1]), .reinit_req(reinit_w[1]), .cmd_reg(cmd_w[1]),
        .sdram_ba(ba_w[1]), .sdram_addr(addr_w[1]), .init_end_flag(flag_w[1]), .busy(busy_w[1]));
    sdram_init_gen #(.CLK_FREQ_MHZ(10), .POWERUP_US(1), .CAS_LAT(3'd2), .BURST_TYPE(1'b1),
                     .BURST_LEN(3'b011)) u_mode (
        .sysclk(clk), .rst(rst_w[2]), .reinit_req(reinit_w[2]), .cmd_reg(cmd_w[2]),
        .sdram_ba(ba_w[2]), .sdram_addr(addr_w[2]), .init_end_flag(flag_w[2]), .busy(busy_w[2]));
    sdram_init_gen #(.CLK_FREQ_MHZ(10), .POWERUP_US(1), .T_RP(1), .T_MRD(1)) u_min (
        .sysclk(clk), .rst(rst_w[3]), .reinit_req(reinit_w[3]), .cmd_reg(cmd_w[3]),
        .sdram_ba(ba_w[3]), .sdram_addr(addr_w[3]), .init_end_flag(flag_w[3]), .busy(busy_w[3]));

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_cmd(input int c, input logic [3:0] cmd, input logic [12:0] a);
        ev_t e;
        e.cyc = c; e.kind = 0; e.val = int'({cmd, a});
        sb.push_back(e);
    endtask

    // Flag event value is {busy, init_end_flag}.
    task automatic push_flag(input int c, input logic v);
        ev_t e;
        e.cyc = c; e.kind = 1; e.val = int'({~v, v});
        sb.push_back(e);
    endtask

    task automatic push_seq(input int start, input int nref, input int rp, input int rfc,
                            input int mrd, input logic [12:0] mode);
        int c;
        c = start;
        push_cmd(c, PRE, 13'h0400);
        c += rp;
        for (int i = 0; i < nref; i++) begin
            push_cmd(c, REF, 13'h0400);
            c += rfc;
        end
        push_cmd(c, MRS, mode);
        push_flag(c + mrd, 1'b1);
    endtask

    task automatic match(input string tag, input int c, input int kind, input int val);
        ev_t e;
        if (sb.size() == 0) begin
            check_val({tag, "_unexpected_at_cycle"}, c, -1);
        end else begin
            e = sb.pop_front();
            check_val({tag, "_cycle"}, c, e.cyc);
            check_val({tag, "_kind"}, kind, e.kind);
            check_val({tag, "_value"}, val, e.val);
        end
    endtask

    task automatic run(input int idx, input int ncyc, input int reinit_at, input int rst_at);
        logic prev_flag;
        rst_w[idx] = 1'b1;
        reinit_w[idx] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_cmd", int'(cmd_w[idx]), int'(NOP));
        check_val("reset_addr", int'(addr_w[idx]), 32'h0400);
        check_val("reset_ba", int'(ba_w[idx]), 0);
        check_val("reset_flag_busy", int'({busy_w[idx], flag_w[idx]}), 2);
        rst_w[idx] = 1'b0;
        prev_flag = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (cmd_w[idx] != NOP) begin
                match("cmd", c, 0, int'({cmd_w[idx], addr_w[idx]}));
            end else if (addr_w[idx] != 13'h0400) begin
                check_val("nop_addr", int'(addr_w[idx]), 32'h0400);
            end
            if (ba_w[idx] != 2'b00) begin
                check_val("bank", int'(ba_w[idx]), 0);
            end
            if (flag_w[idx] != prev_flag) begin
                match("flag", c, 1, int'({busy_w[idx], flag_w[idx]}));
            end
            prev_flag = flag_w[idx];
            rst_w[idx] = (c == rst_at);
            reinit_w[idx] = (c == reinit_at);
        end
        rst_w[idx] = 1'b1;
        reinit_w[idx] = 1'b0;
        check_val("scoreboard_drained", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        // Nominal sequence
        push_seq(11, 2, 2, 7, 2, 13'h0032);
        run(0, 40, 0, 0);

        // Re-init from S_DONE skips the power-up wait
        push_seq(11, 2, 2, 7, 2, 13'h0032);
        push_cmd(41, PRE, 13'h0400);
        push_flag(41, 1'b0);
        push_cmd(43, REF, 13'h0400);
        push_cmd(50, REF, 13'h0400);
        push_cmd(57, MRS, 13'h0032);
        push_flag(59, 1'b1);
        run(0, 65, 40, 0);

        // Mid-sequence re-init is ignored
        push_seq(11, 2, 2, 7, 2, 13'h0032);
        run(0, 40, 15, 0);

        // Mid-sequence reset aborts and restarts the full power-up wait
        push_cmd(11, PRE, 13'h0400);
        push_cmd(13, REF, 13'h0400);
        push_seq(30, 2, 2, 7, 2, 13'h0032);
        run(0, 55, 0, 18);

        // Reset and re-init together in S_DONE: reset wins
        push_seq(11, 2, 2, 7, 2, 13'h0032);
        push_flag(36, 1'b0);
        push_seq(47, 2, 2, 7, 2, 13'h0032);
        run(0, 70, 35, 35);

        // Four refreshes with short tRFC
        push_seq(11, 4, 2, 3, 2, 13'h0032);
        run(1, 35, 0, 0);

        // Alternate mode word
        push_seq(11, 2, 2, 7, 2, 13'h002B);
        run(2, 40, 0, 0);

        // Minimum tRP and tMRD
        push_seq(11, 2, 1, 7, 1, 13'h0032);
        run(3, 35, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
